// File: rtl/bp_stream_host.sv
// rtl/bp_stream_host.sv - stream-to-MMIO write host: address word + data beats in, one write command out, optional ack word back
//
// Receives a word stream (one address word, then data beats LSB first),
// issues a single write command to the MMIO target, waits for its response
// and, when BP_STREAM_HOST_ACK_EN is defined, returns the address as an ack
// word on the outbound stream. One command is outstanding at a time.
//
// Optional feature macro: BP_STREAM_HOST_ACK_EN
//   defined   : SEND_ACK state returns the address on stream_v_o/stream_data_o
//   undefined : no ack; stream_v_o/stream_data_o tied to 0, stream_yumi_i ignored
//
// Ports:
//   clk_i, reset_i               clock, asynchronous active-high reset
//   stream_v_i/_data_i/_ready_o  inbound word stream (valid/ready)
//   cmd_v_o/_addr_o/_data_o      write command toward target
//   cmd_ready_i                  target accepts command
//   resp_v_i/resp_ready_o        target response (payload ignored)
//   stream_v_o/_data_o           outbound ack word
//   stream_yumi_i                outbound ack consumed (valid-then-yumi)

module bp_stream_host #(
    parameter int stream_data_width_p = 32,
    parameter int addr_width_p        = 32,
    parameter int data_width_p        = 64
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic                           stream_v_i,
    input  logic [stream_data_width_p-1:0] stream_data_i,
    output logic                           stream_ready_o,
    output logic                           cmd_v_o,
    output logic [addr_width_p-1:0]        cmd_addr_o,
    output logic [data_width_p-1:0]        cmd_data_o,
    input  logic                           cmd_ready_i,
    input  logic                           resp_v_i,
    output logic                           resp_ready_o,
    output logic                           stream_v_o,
    output logic [stream_data_width_p-1:0] stream_data_o,
    input  logic                           stream_yumi_i
);

    localparam int beats_lp     = data_width_p / stream_data_width_p;
    localparam int cnt_width_lp = (beats_lp > 1) ? $clog2(beats_lp) : 1;
    localparam logic [cnt_width_lp-1:0] last_beat_lp = cnt_width_lp'(beats_lp - 1);

    typedef enum logic [2:0] {
        RX_ADDR   = 3'd0,
        RX_DATA   = 3'd1,
        SEND_CMD  = 3'd2,
        WAIT_RESP = 3'd3,
        SEND_ACK  = 3'd4
    } state_e;

    state_e                    state_q, state_d;
    logic [cnt_width_lp-1:0]   cnt_q, cnt_d;
    logic [addr_width_p-1:0]   addr_q, addr_d;
    logic [data_width_p-1:0]   data_q, data_d;

    // State register
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= RX_ADDR;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        case (state_q)
            RX_ADDR: begin
                if (stream_v_i) begin
                    addr_d  = stream_data_i[addr_width_p-1:0];
                    cnt_d   = '0;
                    state_d = RX_DATA;
                end
            end
            RX_DATA: begin
                if (stream_v_i) begin
                    for (int i = 0; i < beats_lp; i++) begin
                        if (cnt_q == cnt_width_lp'(i)) begin
                            data_d[i*stream_data_width_p +: stream_data_width_p] = stream_data_i;
                        end
                    end
                    // Counter stops at the last beat so it never wraps.
                    if (cnt_q == last_beat_lp) begin
                        state_d = SEND_CMD;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            SEND_CMD: begin
                if (cmd_ready_i) begin
                    state_d = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                if (resp_v_i) begin
`ifdef BP_STREAM_HOST_ACK_EN
                    state_d = SEND_ACK;
`else
                    state_d = RX_ADDR;
`endif
                end
            end
`ifdef BP_STREAM_HOST_ACK_EN
            SEND_ACK: begin
                if (stream_yumi_i) begin
                    state_d = RX_ADDR;
                end
            end
`endif
            default: state_d = RX_ADDR;
        endcase
    end

    // Outputs: decoded from state only; forced low while reset is asserted.
    always_comb begin
        stream_ready_o = 1'b0;
        cmd_v_o        = 1'b0;
        cmd_addr_o     = '0;
        cmd_data_o     = '0;
        resp_ready_o   = 1'b0;
        stream_v_o     = 1'b0;
        stream_data_o  = '0;
        if (!reset_i) begin
            case (state_q)
                RX_ADDR, RX_DATA: stream_ready_o = 1'b1;
                SEND_CMD: begin
                    cmd_v_o    = 1'b1;
                    cmd_addr_o = addr_q;
                    cmd_data_o = data_q;
                end
                WAIT_RESP: resp_ready_o = 1'b1;
`ifdef BP_STREAM_HOST_ACK_EN
                SEND_ACK: begin
                    stream_v_o    = 1'b1;
                    stream_data_o = stream_data_width_p'(addr_q);
                end
`endif
                default: ;
            endcase
        end
    end

`ifdef BP_STREAM_HOST_ACK_EN
    // Yumi is only legal while the ack word is being offered.
    assert property (@(posedge clk_i) disable iff (reset_i) stream_yumi_i |-> stream_v_o)
        else $error("stream_yumi_i asserted without stream_v_o");
`else
    logic unused_yumi;
    assign unused_yumi = stream_yumi_i;
`endif

endmodule

// File: tb/tb_bp_stream_host.sv
// tb/tb_bp_stream_host.sv - directed self-checking bench for bp_stream_host
module tb_bp_stream_host;

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        stream_v_i = 1'b0;
    logic [31:0] stream_data_i = '0;
    logic        stream_ready_o;
    logic        cmd_v_o;
    logic [31:0] cmd_addr_o;
    logic [63:0] cmd_data_o;
    logic        cmd_ready_i = 1'b0;
    logic        resp_v_i = 1'b0;
    logic        resp_ready_o;
    logic        stream_v_o;
    logic [31:0] stream_data_o;
    logic        stream_yumi_i = 1'b0;

    int checks = 0;
    int errors = 0;

    bp_stream_host dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .stream_v_i    (stream_v_i),
        .stream_data_i (stream_data_i),
        .stream_ready_o(stream_ready_o),
        .cmd_v_o       (cmd_v_o),
        .cmd_addr_o    (cmd_addr_o),
        .cmd_data_o    (cmd_data_o),
        .cmd_ready_i   (cmd_ready_i),
        .resp_v_i      (resp_v_i),
        .resp_ready_o  (resp_ready_o),
        .stream_v_o    (stream_v_o),
        .stream_data_o (stream_data_o),
        .stream_yumi_i (stream_yumi_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Offers one word and returns #1 after the edge where it was accepted.
    task automatic send_word(input logic [31:0] w);
        int n;
        stream_v_i    = 1'b1;
        stream_data_i = w;
        n = 0;
        #1;
        while (stream_ready_o !== 1'b1 && n < 20) begin
            @(posedge clk_i); #1;
            n++;
        end
        chk("send_bound", 64'(n < 20), 64'd1);
        @(posedge clk_i); #1;
        stream_v_i = 1'b0;
    endtask

    task automatic outputs_zero(input string tag);
        chk({tag, "_ready"}, 64'(stream_ready_o), 64'd0);
        chk({tag, "_cmd_v"}, 64'(cmd_v_o), 64'd0);
        chk({tag, "_addr"}, 64'(cmd_addr_o), 64'd0);
        chk({tag, "_data"}, cmd_data_o, 64'd0);
        chk({tag, "_resp_rdy"}, 64'(resp_ready_o), 64'd0);
        chk({tag, "_sv"}, 64'(stream_v_o), 64'd0);
        chk({tag, "_sdata"}, 64'(stream_data_o), 64'd0);
    endtask

    initial begin
        // Reset state
        #2;
        outputs_zero("rst");
        @(posedge clk_i); #1;
        reset_i = 1'b0;
        #1;
        chk("post_rst_ready", 64'(stream_ready_o), 64'd1);

        // Transaction 1 with a 5-cycle command stall
        send_word(32'h0000_1000);
        send_word(32'hDEAD_BEEF);
        send_word(32'h0123_4567);
        chk("t1_cmd_v_latency", 64'(cmd_v_o), 64'd1);
        chk("t1_addr", 64'(cmd_addr_o), 64'h1000);
        chk("t1_data", cmd_data_o, 64'h0123_4567_DEAD_BEEF);
        resp_v_i = 1'b1;
        #1;
        chk("resp_rdy_in_cmd", 64'(resp_ready_o), 64'd0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_i); #1;
            resp_v_i = 1'b0;
            chk("stall_cmd_v", 64'(cmd_v_o), 64'd1);
            chk("stall_addr", 64'(cmd_addr_o), 64'h1000);
            chk("stall_data", cmd_data_o, 64'h0123_4567_DEAD_BEEF);
            chk("stall_ready", 64'(stream_ready_o), 64'd0);
        end
        cmd_ready_i = 1'b1;
        @(posedge clk_i); #1;
        cmd_ready_i = 1'b0;
        #1;
        chk("t1_cmd_done", 64'(cmd_v_o), 64'd0);
        chk("t1_resp_rdy", 64'(resp_ready_o), 64'd1);

        // Second address offered while the first is outstanding
        stream_v_i    = 1'b1;
        stream_data_i = 32'h0000_2000;
        #1;
        chk("wr_bp_ready", 64'(stream_ready_o), 64'd0);
        @(posedge clk_i); #1;
        chk("wr_still_wait", 64'(resp_ready_o), 64'd1);
        resp_v_i = 1'b1;
        @(posedge clk_i); #1;
        resp_v_i = 1'b0;
        #1;
`ifdef BP_STREAM_HOST_ACK_EN
        chk("ack_v", 64'(stream_v_o), 64'd1);
        chk("ack_data", 64'(stream_data_o), 64'h1000);
        chk("ack_bp_ready", 64'(stream_ready_o), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i); #1;
            chk("ack_hold_v", 64'(stream_v_o), 64'd1);
            chk("ack_hold_data", 64'(stream_data_o), 64'h1000);
            chk("ack_hold_ready", 64'(stream_ready_o), 64'd0);
        end
        stream_yumi_i = 1'b1;
        @(posedge clk_i); #1;
        stream_yumi_i = 1'b0;
        #1;
        chk("yumi_sv_drop", 64'(stream_v_o), 64'd0);
        chk("yumi_rx_addr", 64'(stream_ready_o), 64'd1);
`else
        chk("noack_sv", 64'(stream_v_o), 64'd0);
        chk("noack_sdata", 64'(stream_data_o), 64'd0);
        chk("noack_ready", 64'(stream_ready_o), 64'd1);
`endif

        // Transaction 2 (pending 0x2000 word is accepted now)
        send_word(32'h0000_2000);
        send_word(32'h0000_0005);
        send_word(32'h0000_0006);
        cmd_ready_i = 1'b1;
        chk("t2_cmd_v", 64'(cmd_v_o), 64'd1);
        chk("t2_addr", 64'(cmd_addr_o), 64'h2000);
        chk("t2_data", cmd_data_o, 64'h0000_0006_0000_0005);
        @(posedge clk_i); #1;
        cmd_ready_i = 1'b0;
        resp_v_i = 1'b1;
        @(posedge clk_i); #1;
        resp_v_i = 1'b0;
`ifdef BP_STREAM_HOST_ACK_EN
        chk("t2_ack_data", 64'(stream_data_o), 64'h2000);
        stream_yumi_i = 1'b1;
        @(posedge clk_i); #1;
        stream_yumi_i = 1'b0;
`else
        chk("t2_noack_sv", 64'(stream_v_o), 64'd0);
`endif
        #1;
        chk("t2_idle_ready", 64'(stream_ready_o), 64'd1);

        // Reset in the middle of a transfer
        send_word(32'h0000_3000);
        send_word(32'h0000_0001);
        #2;
        reset_i = 1'b1;
        #1;
        outputs_zero("mid_rst");
        #3;
        reset_i = 1'b0;
        #1;
        chk("mid_rst_ready", 64'(stream_ready_o), 64'd1);
        chk("mid_rst_no_cmd", 64'(cmd_v_o), 64'd0);
        send_word(32'h0000_3000);
        send_word(32'h0000_0001);
        chk("t3_no_early_cmd", 64'(cmd_v_o), 64'd0);
        send_word(32'h0000_0002);
        chk("t3_cmd_v", 64'(cmd_v_o), 64'd1);
        chk("t3_addr", 64'(cmd_addr_o), 64'h3000);
        chk("t3_data", cmd_data_o, 64'h0000_0002_0000_0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bp_stream_host.md
Name: bp_stream_host

Overview:
- Far-end counterpart of the MMIO-to-stream bridge.
- Deserializes the word stream that bridge emits (one address word, then data beats) into single write commands toward an MMIO/memory target.
- Consumes the target's response and returns one acknowledge word on the reverse stream.
- Sits on the host/FPGA side of the chip link; one command outstanding at a time.

Parameters:
- stream_data_width_p, 32, width of one stream word.
- addr_width_p, 32, command address width; must be <= stream_data_width_p.
- data_width_p, 64, command data width; must be a nonzero multiple of stream_data_width_p.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  reset; asynchronous, active-high
- stream_v_i  in  1  inbound word valid
- stream_data_i  in  stream_data_width_p  inbound word
- stream_ready_o  out  1  inbound ready (valid/ready handshake)
- cmd_v_o  out  1  write command valid
- cmd_addr_o  out  addr_width_p  command address
- cmd_data_o  out  data_width_p  command data
- cmd_ready_i  in  1  target accepts command
- resp_v_i  in  1  target response valid
- resp_ready_o  out  1  response ready
- stream_v_o  out  1  outbound ack valid
- stream_data_o  out  stream_data_width_p  outbound ack word
- stream_yumi_i  in  1  outbound ack consumed (valid-then-yumi)

Behaviour:
- Clock and reset: single clock clk_i. reset_i is asynchronous and active-high; all state flops clear immediately on assertion.
- Reset values:
  - state = RX_ADDR; beat counter = 0; addr/data registers = 0.
  - All outputs 0: stream_ready_o, cmd_v_o, resp_ready_o, stream_v_o, cmd_addr_o, cmd_data_o, stream_data_o.
- Beats: beats = data_width_p/stream_data_width_p; counter width = max(1, clog2(beats)).
- States:
  - RX_ADDR:
    - stream_ready_o=1.
    - On stream_v_i & stream_ready_o: latch stream_data_i[addr_width_p-1:0] into the address register; counter=0; go to RX_DATA.
  - RX_DATA:
    - stream_ready_o=1.
    - On each accepted word: write the word into data slice [counter*stream_data_width_p +: stream_data_width_p]. Beats are LSB first.
    - On the last beat (counter==beats-1): go to SEND_CMD; otherwise counter++.
  - SEND_CMD:
    - cmd_v_o=1; cmd_addr_o/cmd_data_o driven from registers.
    - Inputs stay stable until cmd_ready_i; on cmd_v_o & cmd_ready_i go to WAIT_RESP.
  - WAIT_RESP:
    - resp_ready_o=1.
    - On resp_v_i go to SEND_ACK; response payload is ignored.
  - SEND_ACK:
    - stream_v_o=1; stream_data_o = address register zero-extended to stream_data_width_p.
    - On stream_yumi_i go to RX_ADDR.
- Handshake rules:
  - stream_ready_o=0 in SEND_CMD, WAIT_RESP and SEND_ACK, so inbound words back-pressure.
  - stream_ready_o is a function of state only; it never depends combinationally on stream_v_i.
  - cmd_v_o does not depend on cmd_ready_i.
- Latency (zero stall):
  - Last inbound beat accepted at cycle N: cmd_v_o is high at N+1.
  - Response accepted at cycle M: stream_v_o is high at M+1.
- Boundary conditions:
  - resp_v_i outside WAIT_RESP is not consumed (resp_ready_o=0).
  - stream_yumi_i without stream_v_o is illegal (assertion).
  - Reset mid-transfer discards the partial address/data; no command is issued.
  - Beat counter never wraps past beats-1.
- Throughput: one transaction per (1 + beats + cmd wait + resp wait + ack wait) cycles. No overlap between transactions.

Optional Feature:
- Macro: BP_STREAM_HOST_ACK_EN
- Defined: SEND_ACK state exists as described.
- Undefined:
  - SEND_ACK is removed; WAIT_RESP goes directly to RX_ADDR on resp_v_i.
  - stream_v_o and stream_data_o are tied to 0; stream_yumi_i is ignored.

Test Plan:
- Default params. Inbound stream 0x0000_1000, 0xDEAD_BEEF, 0x0123_4567; cmd_ready_i=1; resp one cycle after cmd.
  -> cmd_addr_o=0x1000, cmd_data_o=0x0123_4567_DEAD_BEEF; stream_data_o=0x0000_1000 with ACK_EN.
- cmd_ready_i held 0 for 5 cycles.
  -> cmd_v_o stays 1 with stable address/data; stream_ready_o=0 throughout; command accepted on cycle 6.
- Second transaction (addr 0x2000) offered while the first is in WAIT_RESP.
  -> 0x2000 is not accepted until after the first ack is yumi'd; commands arrive in order 0x1000 then 0x2000.
- reset_i asserted asynchronously after the address word and one data beat.
  -> all outputs 0 immediately; new transaction 0x3000/0x1/0x2 yields cmd_data_o=0x0000_0002_0000_0001.
- stream_yumi_i delayed 3 cycles in SEND_ACK.
  -> stream_v_o stays 1 with constant data for 3 cycles; RX_ADDR is re-entered the cycle after yumi.
- Build without BP_STREAM_HOST_ACK_EN, full transaction.
  -> stream_v_o never asserts; stream_ready_o returns to 1 the cycle after resp_v_i.
